// File: rtl/wb_arbiter3_rr_wdt_pkg.sv
// Shared definitions for the three-master Wishbone arbiter.
// Contents: FSM state encodings and a constant-evaluable clog2 helper.
package wb_arbiter3_rr_wdt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // Ceiling log2; clog2(1) = 0, clog2(256) = 8.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_arbiter3_rr_wdt_pick.sv
// wb_rr_pick3: combinational three-way round-robin picker.
// Ports:
//   request[2:0] - request lines
//   last[1:0]    - index granted most recently
//   pick[2:0]    - one-hot winner (0 when no request)
//   idx[1:0]     - encoded winner (0 when no request)
// The scan order is last+1, last+2, last (mod 3).
module wb_rr_pick3 (
    input  logic [2:0] request,
    input  logic [1:0] last,
    output logic [2:0] pick,
    output logic [1:0] idx
);

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    logic [1:0] cand [3];
    logic       found;

    always_comb begin
        cand[0] = inc3(last);
        cand[1] = inc3(cand[0]);
        // Third candidate is last itself for legal values; an illegal
        // last of 3 still yields a full permutation of 0,1,2.
        cand[2] = inc3(cand[1]);
        found   = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && request[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
        pick = found ? (3'b001 << idx) : 3'b000;
    end

endmodule

// File: rtl/wb_arbiter3_rr_wdt.sv
// Three-master to one-slave Wishbone arbiter with round-robin grant and a
// bus watchdog that forces an error termination on a stuck slave.
// Ports:
//   clk, rst (sync, active-high)
//   wbmN_* (N=0..2)  master-side Wishbone ports
//   wbs_*            slave-side Wishbone port
//   grant_o          one-hot current grant, 0 when idle
//   timeout_o        one-cycle pulse when the watchdog fires
module wb_arbiter3_rr_wdt
    import wb_arbiter3_rr_wdt_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INIT_LAST      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    input  logic [ADDR_WIDTH-1:0]   wbm2_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm2_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm2_dat_o,
    input  logic                    wbm2_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm2_sel_i,
    input  logic                    wbm2_stb_i,
    input  logic                    wbm2_cyc_i,
    output logic                    wbm2_ack_o,
    output logic                    wbm2_err_o,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    output logic [2:0]              grant_o,
    output logic                    timeout_o
);

    localparam int CNT_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit WDT_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] WDT_LIMIT = CNT_W'(WDT_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [ADDR_WIDTH-1:0]   m_adr [3];
    logic [DATA_WIDTH-1:0]   m_dat [3];
    logic [SELECT_WIDTH-1:0] m_sel [3];
    logic [2:0]              m_we;
    logic [2:0]              m_stb;
    logic [2:0]              m_cyc;

    assign m_adr = '{wbm0_adr_i, wbm1_adr_i, wbm2_adr_i};
    assign m_dat = '{wbm0_dat_i, wbm1_dat_i, wbm2_dat_i};
    assign m_sel = '{wbm0_sel_i, wbm1_sel_i, wbm2_sel_i};
    assign m_we  = {wbm2_we_i,  wbm1_we_i,  wbm0_we_i};
    assign m_stb = {wbm2_stb_i, wbm1_stb_i, wbm0_stb_i};
    assign m_cyc = {wbm2_cyc_i, wbm1_cyc_i, wbm0_cyc_i};

    logic [1:0]       state_reg;
    logic [2:0]       grant_reg;
    logic [1:0]       last_reg;
    logic [CNT_W-1:0] wdt_cnt_reg;
    logic             err_first_reg;

    logic [2:0] pick;
    logic [1:0] pick_idx;

    wb_rr_pick3 u_pick (
        .request (m_cyc),
        .last    (last_reg),
        .pick    (pick),
        .idx     (pick_idx)
    );

    logic busy;
    logic g_cyc;
    logic g_stb;

    assign busy  = (state_reg == ST_BUSY);
    assign g_cyc = |(grant_reg & m_cyc);
    assign g_stb = |(grant_reg & m_stb);

    // One-hot AND-OR mux of the granted master onto the slave port.
    logic [ADDR_WIDTH-1:0]   sel_adr;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic [SELECT_WIDTH-1:0] sel_sel;

    always_comb begin
        sel_adr = '0;
        sel_dat = '0;
        sel_sel = '0;
        for (int k = 0; k < 3; k++) begin
            if (grant_reg[k]) begin
                sel_adr = sel_adr | m_adr[k];
                sel_dat = sel_dat | m_dat[k];
                sel_sel = sel_sel | m_sel[k];
            end
        end
    end

    // Outside BUSY (including ERR) the slave sees an all-zero bus.
    assign wbs_adr_o = busy ? sel_adr : '0;
    assign wbs_dat_o = busy ? sel_dat : '0;
    assign wbs_sel_o = busy ? sel_sel : '0;
    assign wbs_we_o  = busy & |(grant_reg & m_we);
    assign wbs_stb_o = busy & g_stb;
    assign wbs_cyc_o = busy;

    logic [2:0] ack_vec;
    logic [2:0] err_vec;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_resp
            assign ack_vec[gi] = wbs_ack_i & grant_reg[gi] & busy;
            assign err_vec[gi] = grant_reg[gi] & err_first_reg;
        end
    endgenerate

    assign wbm0_ack_o = ack_vec[0];
    assign wbm1_ack_o = ack_vec[1];
    assign wbm2_ack_o = ack_vec[2];
    assign wbm0_err_o = err_vec[0];
    assign wbm1_err_o = err_vec[1];
    assign wbm2_err_o = err_vec[2];
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm2_dat_o = wbs_dat_i;
    assign grant_o    = grant_reg;
    assign timeout_o  = err_first_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 3'b000;
            last_reg      <= 2'(INIT_LAST);
            wdt_cnt_reg   <= '0;
            err_first_reg <= 1'b0;
        end else begin
            err_first_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    wdt_cnt_reg <= '0;
                    if (|m_cyc) begin
                        grant_reg <= pick;
                        last_reg  <= pick_idx;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Cycle end has priority over a watchdog fire in the
                    // same cycle; an ack likewise suppresses the fire.
                    if (!g_cyc) begin
                        state_reg   <= ST_IDLE;
                        grant_reg   <= 3'b000;
                        wdt_cnt_reg <= '0;
                    end else if (g_stb && !wbs_ack_i) begin
                        if (WDT_EN && wdt_cnt_reg == WDT_LIMIT) begin
                            state_reg     <= ST_ERR;
                            err_first_reg <= 1'b1;
                            wdt_cnt_reg   <= '0;
                        end else if (WDT_EN && wdt_cnt_reg != '1) begin
                            wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
                        end
                    end else begin
                        wdt_cnt_reg <= '0;
                    end
                end
                ST_ERR: begin
                    wdt_cnt_reg <= '0;
                    if (!g_cyc) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= 3'b000;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    grant_reg   <= 3'b000;
                    wdt_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule
